// File: rtl/lsu_mem_req.sv
// Load/store request sequencer feeding a latency-programmable memory controller.
// Checks alignment, drives word-aligned requests with byte masks, and returns extended load data.
module lsu_mem_req #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  output logic        mem_wen,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          store_q, store_d;
  logic [2:0]    func3_q, func3_d;
  logic [1:0]    off_q, off_d;

  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_err_q, resp_err_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          mem_valid_q, mem_valid_d;
  logic          mem_wen_q, mem_wen_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_wmask_q, mem_wmask_d;

  logic          req_legal;
  logic          last_beat;
  logic [31:0]   st_wdata;
  logic [3:0]    st_wmask;
  logic [31:0]   ld_shift;
  logic [31:0]   ld_data;

  assign last_beat = (cnt_q == CW'(1));
  assign ld_shift  = mem_rdata >> {off_q, 3'b000};

  // NOTE: every always_comb assigns its outputs a default first, so no path can infer a latch.
  always_comb begin
    req_legal = 1'b0;
    case (req_func3)
      3'b000:  req_legal = 1'b1;
      3'b001:  req_legal = ~req_addr[0];
      3'b010:  req_legal = (req_addr[1:0] == 2'b00);
      3'b100:  req_legal = ~req_wen;
      3'b101:  req_legal = ~req_wen & ~req_addr[0];
      default: req_legal = 1'b0;
    endcase
  end

  // Store lanes: data replicated across the word, mask selects the addressed bytes.
  always_comb begin
    st_wdata = req_wdata;
    st_wmask = 4'b1111;
    case (req_func3[1:0])
      2'b00: begin
        st_wdata = {4{req_wdata[7:0]}};
        st_wmask = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{req_wdata[15:0]}};
        st_wmask = 4'b0011 << req_addr[1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data = mem_rdata;
    case (func3_q)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b100:  ld_data = {24'h0, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b101:  ld_data = {16'h0, ld_shift[15:0]};
      default: ld_data = mem_rdata;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    store_d = store_q;
    func3_d = func3_q;
    off_d   = off_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          store_d = req_wen;
          func3_d = req_func3;
          off_d   = req_addr[1:0];
          if (req_legal) begin
            state_d = S_ACCESS;
            cnt_d   = CW'(LATENCY);
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_ACCESS: begin
        if (last_beat) state_d = S_RESP;
        else           cnt_d   = cnt_q - CW'(1);
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered-output logic: computes what every output shows in the next state.
  always_comb begin
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    mem_valid_d  = 1'b0;
    mem_wen_d    = 1'b0;
    mem_wmask_d  = 4'b0000;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_legal) begin
            mem_valid_d = 1'b1;
            mem_wen_d   = req_wen;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            if (req_wen) begin
              mem_wdata_d = st_wdata;
              mem_wmask_d = st_wmask;
            end
          end else begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end
        end
      end
      S_ACCESS: begin
        // A store writes only in its first beat; a load holds valid until the sampling beat.
        mem_valid_d = ~store_q & ~last_beat;
        if (last_beat) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = store_q ? 32'h0 : ld_data;
        end
      end
      S_RESP: begin
        if (resp_ready) resp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      store_q      <= 1'b0;
      func3_q      <= 3'b000;
      off_q        <= 2'b00;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      mem_valid_q  <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_wmask_q  <= 4'b0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      store_q      <= store_d;
      func3_q      <= func3_d;
      off_q        <= off_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_valid_q  <= mem_valid_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wmask_q  <= mem_wmask_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_valid  = mem_valid_q;
  assign mem_wen    = mem_wen_q;
  assign mem_raddr  = mem_addr_q;
  assign mem_waddr  = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wmask  = {4'b0000, mem_wmask_q};

endmodule

// File: tb/tb_lsu_mem_req.sv
// Bench for lsu_mem_req: three instances (LATENCY 1, 3, 4) each backed by a small word memory,
// checked against a byte-addressed reference model of RISC-V load/store semantics.
module tb_lsu_mem_req;

  localparam int NI = 3;

  logic        clk;
  logic        rst_n;
  logic        mem_init;

  logic        req_valid  [NI];
  logic        req_ready  [NI];
  logic        req_wen    [NI];
  logic [2:0]  req_func3  [NI];
  logic [31:0] req_addr   [NI];
  logic [31:0] req_wdata  [NI];
  logic        resp_valid [NI];
  logic        resp_ready [NI];
  logic [31:0] resp_rdata [NI];
  logic        resp_err   [NI];
  logic        mem_valid  [NI];
  logic        mem_wen    [NI];
  logic [31:0] mem_raddr  [NI];
  logic [31:0] mem_waddr  [NI];
  logic [31:0] mem_wdata  [NI];
  logic [7:0]  mem_wmask  [NI];
  logic        rd_force   [NI];
  logic [31:0] rd_val     [NI];

  logic [31:0] cmem   [NI][16];
  int          wr_cnt [NI];
  logic [7:0]  ref_mem [NI][64];

  int checks;
  int failures;

  typedef struct packed {
    logic        ready0;
    logic        valid1;
    logic [31:0] raddr1;
    int          nvalid;
    int          nwrites;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [7:0]  wmask;
    logic        addr_bad;
    logic        quiet_bad;
    int          resp_n;
    logic [31:0] rdata;
    logic        err;
    logic        done_ok;
  } op_obs_t;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    lsu_mem_req #(.LATENCY((g == 0) ? 1 : ((g == 1) ? 3 : 4))) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_wen    (req_wen[g]),
      .req_func3  (req_func3[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g]),
      .mem_valid  (mem_valid[g]),
      .mem_wen    (mem_wen[g]),
      .mem_raddr  (mem_raddr[g]),
      .mem_waddr  (mem_waddr[g]),
      .mem_wdata  (mem_wdata[g]),
      .mem_wmask  (mem_wmask[g]),
      .mem_rdata  (rd_force[g] ? rd_val[g] : cmem[g][mem_raddr[g][5:2]])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int k, input int i);
    return (32'h9E37_79B9 * 32'(i + 1)) ^ {8'(k), 24'h5A_5A5A};
  endfunction

  // Memory controller stand-in: combinational read, byte-masked write at the clock edge.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (mem_init) begin
        for (int i = 0; i < 16; i++) cmem[k][i] <= init_word(k, i);
        wr_cnt[k] <= 0;
      end else if (mem_valid[k] && mem_wen[k]) begin
        for (int b = 0; b < 4; b++)
          if (mem_wmask[k][b]) cmem[k][mem_waddr[k][5:2]][8*b +: 8] <= mem_wdata[k][8*b +: 8];
        wr_cnt[k] <= wr_cnt[k] + 1;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int ref_size(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit ref_legal(input logic wen, input logic [2:0] f3, input logic [31:0] addr);
    int size;
    size = ref_size(f3);
    if (size == 0) return 1'b0;
    if (wen && f3[2]) return 1'b0;
    if (!wen && f3 == 3'b110) return 1'b0;
    return (int'(addr[1:0]) % size) == 0;
  endfunction

  function automatic logic [31:0] ref_load(input int k, input logic [2:0] f3, input logic [31:0] addr);
    int size;
    int base;
    logic [31:0] v;
    size = ref_size(f3);
    base = int'(addr[5:0]);
    v = 32'h0;
    for (int i = 0; i < size; i++) v = v | (32'(ref_mem[k][base + i]) << (8 * i));
    if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'h1 << (8 * size)) - 32'h1);
    return v;
  endfunction

  task automatic ref_store(input int k, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] d);
    int base;
    base = int'(addr[5:0]);
    for (int i = 0; i < ref_size(f3); i++) ref_mem[k][base + i] = d[8*i +: 8];
  endtask

  task automatic ref_store_port(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] d,
                                output logic [31:0] wd, output logic [7:0] m);
    int size;
    size = ref_size(f3);
    wd = 32'h0;
    m  = 8'h00;
    for (int i = 0; i < 4; i++) begin
      m[i] = (i >= int'(off)) && (i < int'(off) + size);
      wd[8*i +: 8] = d[8*(i % size) +: 8];
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and observe the instance until its response handshake.
  task automatic do_op(input int k, input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] d, output op_obs_t o);
    logic [31:0] word;
    word = {addr[31:2], 2'b00};
    o = '0;
    req_wen[k]   = wen;
    req_func3[k] = f3;
    req_addr[k]  = addr;
    req_wdata[k] = d;
    req_valid[k] = 1'b1;
    o.ready0 = req_ready[k];
    tick();
    req_valid[k] = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      if (n == 1) begin
        o.valid1 = mem_valid[k];
        o.raddr1 = mem_raddr[k];
      end
      if (mem_valid[k]) begin
        o.nvalid++;
        if (mem_raddr[k] !== word || mem_waddr[k] !== word) o.addr_bad = 1'b1;
        if (mem_wen[k]) begin
          o.nwrites++;
          o.waddr = mem_waddr[k];
          o.wdata = mem_wdata[k];
          o.wmask = mem_wmask[k];
        end
      end else if (mem_wen[k] !== 1'b0 || mem_wmask[k] !== 8'h00) begin
        o.quiet_bad = 1'b1;
      end
      if (resp_valid[k]) begin
        o.resp_n = n;
        o.rdata  = resp_rdata[k];
        o.err    = resp_err[k];
        break;
      end
      tick();
    end
    if (o.resp_n != 0 && resp_ready[k]) begin
      tick();
      o.done_ok = (resp_valid[k] === 1'b0) && (req_ready[k] === 1'b1);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [140:0] got;
    logic [140:0] want;
    want = {1'b1, 140'h0};
    for (int phase = 0; phase < 2; phase++) begin
      for (int k = 0; k < NI; k++) begin
        got = {req_ready[k], resp_valid[k], resp_err[k], resp_rdata[k], mem_valid[k], mem_wen[k],
               mem_raddr[k], mem_waddr[k], mem_wdata[k], mem_wmask[k]};
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL reset[%0d] phase %0d outputs got=%h want=%h", k, phase, got, want);
        end
      end
      if (phase == 0) begin
        @(negedge clk);
        rst_n = 1'b1;
        tick();
      end
    end
  endtask

  task automatic test_lw_basic();
    op_obs_t o;
    rd_force[0] = 1'b1;
    rd_val[0]   = 32'hDEAD_BEEF;
    do_op(0, 1'b0, 3'b010, 32'h8000_0004, 32'h0, o);
    checks++; if (o.ready0 !== 1'b1) begin failures++; $display("FAIL lw_basic req_ready got=%b want=1", o.ready0); end
    checks++; if (o.valid1 !== 1'b1) begin failures++; $display("FAIL lw_basic mem_valid@T+1 got=%b want=1", o.valid1); end
    checks++; if (o.raddr1 !== 32'h8000_0004) begin failures++; $display("FAIL lw_basic raddr got=%h want=80000004", o.raddr1); end
    checks++; if (o.resp_n != 2) begin failures++; $display("FAIL lw_basic resp cycle got=T+%0d want=T+2", o.resp_n); end
    checks++; if (o.rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_basic rdata got=%h want=deadbeef", o.rdata); end
    checks++; if (o.err !== 1'b0) begin failures++; $display("FAIL lw_basic err got=%b want=0", o.err); end
    checks++; if (o.done_ok !== 1'b1) begin failures++; $display("FAIL lw_basic handshake got=%b want=1", o.done_ok); end
    rd_force[0] = 1'b0;
  endtask

  task automatic test_load_extract();
    op_obs_t o;
    logic [2:0]  f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
    logic [31:0] ad  [5] = '{32'h8000_0003, 32'h8000_0003, 32'h8000_0002, 32'h8000_0002, 32'h8000_0001};
    logic [31:0] exp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF, 32'h0000_0012};
    rd_force[0] = 1'b1;
    rd_val[0]   = 32'h80FF_1234;
    for (int i = 0; i < 5; i++) begin
      do_op(0, 1'b0, f3[i], ad[i], 32'h0, o);
      checks++;
      if (o.rdata !== exp[i] || o.err !== 1'b0 || o.resp_n != 2) begin
        failures++;
        $display("FAIL extract[%0d] f3=%b rdata=%h err=%b n=%0d want rdata=%h err=0 n=2",
                 i, f3[i], o.rdata, o.err, o.resp_n, exp[i]);
      end
    end
    rd_force[0] = 1'b0;
  endtask

  task automatic test_store_l3();
    op_obs_t o;
    int w0;
    w0 = wr_cnt[1];
    do_op(1, 1'b1, 3'b001, 32'h8000_0006, 32'h1234_ABCD, o);
    ref_store(1, 3'b001, 32'h8000_0006, 32'h1234_ABCD);
    checks++; if (o.nwrites != 1 || o.nvalid != 1) begin failures++; $display("FAIL sh writes=%0d valid_cycles=%0d want 1/1", o.nwrites, o.nvalid); end
    checks++; if (o.waddr !== 32'h8000_0004) begin failures++; $display("FAIL sh waddr got=%h want=80000004", o.waddr); end
    checks++; if (o.wdata !== 32'hABCD_ABCD) begin failures++; $display("FAIL sh wdata got=%h want=abcdabcd", o.wdata); end
    checks++; if (o.wmask !== 8'h0C) begin failures++; $display("FAIL sh wmask got=%h want=0c", o.wmask); end
    checks++; if (o.resp_n != 4) begin failures++; $display("FAIL sh resp cycle got=T+%0d want=T+4", o.resp_n); end
    checks++; if (o.rdata !== 32'h0 || o.err !== 1'b0) begin failures++; $display("FAIL sh resp rdata=%h err=%b want 0/0", o.rdata, o.err); end
    checks++; if (wr_cnt[1] - w0 != 1) begin failures++; $display("FAIL sh controller writes got=%0d want=1", wr_cnt[1] - w0); end
  endtask

  task automatic test_illegal();
    op_obs_t o;
    logic        wen [2] = '{1'b0, 1'b1};
    logic [2:0]  f3  [2] = '{3'b010, 3'b011};
    logic [31:0] ad  [2] = '{32'h8000_0002, 32'h8000_0000};
    int w0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 2; i++) begin
        w0 = wr_cnt[k];
        do_op(k, wen[i], f3[i], ad[i], 32'hFFFF_FFFF, o);
        checks++;
        if (o.nvalid != 0 || o.resp_n != 1 || o.err !== 1'b1 || o.rdata !== 32'h0 || wr_cnt[k] != w0 || !o.done_ok) begin
          failures++;
          $display("FAIL illegal[%0d][%0d] valid_cycles=%0d n=%0d err=%b rdata=%h want 0/1/1/0",
                   k, i, o.nvalid, o.resp_n, o.err, o.rdata);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int k;
    int n1;
    int n2;
    bit stable;
    logic [31:0] a1, a2, exp1, exp2, got1;
    k  = 1;
    a1 = 32'h8000_0008;
    a2 = 32'h8000_0010;
    exp1 = ref_load(k, 3'b010, a1);
    exp2 = ref_load(k, 3'b010, a2);
    resp_ready[k] = 1'b0;
    req_wen[k] = 1'b0; req_func3[k] = 3'b010; req_addr[k] = a1; req_valid[k] = 1'b1;
    tick();
    req_valid[k] = 1'b0;
    n1 = 0;
    for (int n = 1; n <= 20; n++) begin
      if (resp_valid[k]) begin n1 = n; break; end
      tick();
    end
    got1 = resp_rdata[k];
    checks++; if (n1 != 4) begin failures++; $display("FAIL bp first resp cycle got=T+%0d want=T+4", n1); end
    checks++; if (got1 !== exp1) begin failures++; $display("FAIL bp first rdata got=%h want=%h", got1, exp1); end
    req_addr[k]  = a2;
    req_valid[k] = 1'b1;
    stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (resp_valid[k] !== 1'b1 || resp_rdata[k] !== exp1 || resp_err[k] !== 1'b0 ||
          req_ready[k] !== 1'b0 || mem_valid[k] !== 1'b0) stable = 1'b0;
    end
    checks++; if (!stable) begin failures++; $display("FAIL bp hold got=unstable want=stable"); end
    resp_ready[k] = 1'b1;
    tick();
    checks++;
    if (resp_valid[k] !== 1'b0 || req_ready[k] !== 1'b1 || mem_valid[k] !== 1'b0) begin
      failures++;
      $display("FAIL bp after handshake resp_valid=%b req_ready=%b mem_valid=%b want 0/1/0",
               resp_valid[k], req_ready[k], mem_valid[k]);
    end
    tick();
    req_valid[k] = 1'b0;
    checks++;
    if (mem_valid[k] !== 1'b1 || mem_raddr[k] !== a2) begin
      failures++;
      $display("FAIL bp second accept mem_valid=%b raddr=%h want 1/%h", mem_valid[k], mem_raddr[k], a2);
    end
    n2 = 0;
    for (int n = 1; n <= 20; n++) begin
      if (resp_valid[k]) begin n2 = n; break; end
      tick();
    end
    checks++;
    if (n2 != 4 || resp_rdata[k] !== exp2) begin
      failures++;
      $display("FAIL bp second resp n=%0d rdata=%h want n=4 rdata=%h", n2, resp_rdata[k], exp2);
    end
    tick();
  endtask

  task automatic test_random(input int k, input int nops);
    op_obs_t o;
    logic wen;
    logic [2:0] f3;
    logic [31:0] addr, d, exp_rd, exp_wd;
    logic [7:0] exp_m;
    bit ok;
    int exp_n, exp_valid, exp_wr;
    for (int i = 0; i < nops; i++) begin
      wen  = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = 32'h8000_0000 | 32'($urandom_range(0, 63));
      if ($urandom_range(0, 2) != 0) addr[1:0] = 2'b00;
      d  = $urandom;
      ok = ref_legal(wen, f3, addr);
      exp_rd = (ok && !wen) ? ref_load(k, f3, addr) : 32'h0;
      exp_wd = 32'h0;
      exp_m  = 8'h00;
      if (ok && wen) ref_store_port(f3, addr[1:0], d, exp_wd, exp_m);
      do_op(k, wen, f3, addr, d, o);
      if (ok && wen) ref_store(k, f3, addr, d);
      exp_n     = ok ? lat_of(k) + 1 : 1;
      exp_valid = !ok ? 0 : (wen ? 1 : lat_of(k));
      exp_wr    = (ok && wen) ? 1 : 0;
      checks++;
      if (o.resp_n != exp_n || o.err !== !ok || o.rdata !== exp_rd) begin
        failures++;
        $display("FAIL rand[%0d] op%0d wen=%b f3=%b a=%h: n=%0d err=%b rdata=%h want n=%0d err=%b rdata=%h",
                 k, i, wen, f3, addr, o.resp_n, o.err, o.rdata, exp_n, !ok, exp_rd);
      end
      checks++;
      if (o.nvalid != exp_valid || o.nwrites != exp_wr || o.addr_bad || o.quiet_bad || !o.ready0 || !o.done_ok) begin
        failures++;
        $display("FAIL rand[%0d] op%0d port: valid_cycles=%0d writes=%0d addr_bad=%b quiet_bad=%b rdy=%b done=%b want %0d/%0d/0/0/1/1",
                 k, i, o.nvalid, o.nwrites, o.addr_bad, o.quiet_bad, o.ready0, o.done_ok, exp_valid, exp_wr);
      end
      if (ok && wen) begin
        checks++;
        if (o.wdata !== exp_wd || o.wmask !== exp_m) begin
          failures++;
          $display("FAIL rand[%0d] op%0d store lanes wdata=%h wmask=%h want %h/%h", k, i, o.wdata, o.wmask, exp_wd, exp_m);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    op_obs_t o;
    int k;
    bit quiet;
    logic [31:0] exp2;
    k = 2;
    req_wen[k] = 1'b0; req_func3[k] = 3'b010; req_addr[k] = 32'h8000_0014; req_valid[k] = 1'b1;
    tick();
    req_valid[k] = 1'b0;
    tick();
    checks++; if (mem_valid[k] !== 1'b1) begin failures++; $display("FAIL rst_mid mem_valid@T+2 got=%b want=1", mem_valid[k]); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_valid[k] !== 1'b0 || resp_valid[k] !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid async drop mem_valid=%b resp_valid=%b want 0/0", mem_valid[k], resp_valid[k]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (req_ready[k] !== 1'b1 || resp_valid[k] !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid after release req_ready=%b resp_valid=%b want 1/0", req_ready[k], resp_valid[k]);
    end
    quiet = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (resp_valid[k] !== 1'b0 || mem_valid[k] !== 1'b0) quiet = 1'b0;
      tick();
    end
    checks++; if (!quiet) begin failures++; $display("FAIL rst_mid abandoned op got=activity want=none"); end
    exp2 = ref_load(k, 3'b010, 32'h8000_0020);
    do_op(k, 1'b0, 3'b010, 32'h8000_0020, 32'h0, o);
    checks++;
    if (o.resp_n != 5 || o.rdata !== exp2 || o.err !== 1'b0 || o.nvalid != 4 || !o.done_ok) begin
      failures++;
      $display("FAIL rst_mid next lw n=%0d rdata=%h err=%b valid_cycles=%0d want 5/%h/0/4",
               o.resp_n, o.rdata, o.err, o.nvalid, exp2);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    mem_init = 1'b1;
    for (int k = 0; k < NI; k++) begin
      req_valid[k]  = 1'b0;
      req_wen[k]    = 1'b0;
      req_func3[k]  = 3'b000;
      req_addr[k]   = 32'h0;
      req_wdata[k]  = 32'h0;
      resp_ready[k] = 1'b1;
      rd_force[k]   = 1'b0;
      rd_val[k]     = 32'h0;
      for (int i = 0; i < 16; i++) begin
        w = init_word(k, i);
        for (int b = 0; b < 4; b++) ref_mem[k][4*i + b] = w[8*b +: 8];
      end
    end
    repeat (2) tick();
    mem_init = 1'b0;

    test_reset();
    test_lw_basic();
    test_load_extract();
    test_store_l3();
    test_illegal();
    test_backpressure();
    test_random(0, 80);
    test_random(1, 80);
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
